shift_add_mult: RTL and testbench

Parametrised sequential multiplier with a start/rdy/done handshake, replacing the fixed-width repeated-addition multiplier in the arithmetic datapath library. It runs a shift-and-add algorithm, so worst-case latency is WIDTH+2 cycles instead of 2^WIDTH. It supports unsigned and two's-complement signed operands, selected per operation, and terminates early once no multiplier bits remain. It is used wherever an area-cheap multi-cycle multiply is acceptable.

---
 rtl/shift_add_mult.sv | 61 ++++++
 tb/tb_shift_add_mult.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/shift_add_mult.sv
// shift_add_mult: multi-cycle shift-and-add multiplier, unsigned or two's-complement per operation
module shift_add_mult #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_b,
    input  logic               start,
    input  logic               mode_signed,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    output logic               rdy,
    output logic               done,
    output logic [2*WIDTH-1:0] P
);
    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
    state_t             state;
    logic               neg;
    logic [2*WIDTH-1:0] rm;
    logic [2*WIDTH-1:0] rp;
    logic [WIDTH-1:0]   rq;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    // magnitudes: the most negative value maps to 2^(WIDTH-1) as an unsigned number
    assign abs_a = (mode_signed && A[WIDTH-1]) ? -A : A;
    assign abs_b = (mode_signed && B[WIDTH-1]) ? -B : B;
    assign rdy   = (state == IDLE);
    assign P     = rp;
    // load on start, add/shift until no multiplier bits remain, then fix the sign and pulse done
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state <= IDLE;
            neg   <= 1'b0;
            rm    <= '0;
            rq    <= '0;
            rp    <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    state <= RUN;
                    neg   <= mode_signed & (A[WIDTH-1] ^ B[WIDTH-1]);
                    rm    <= {{WIDTH{1'b0}}, abs_a};
                    rq    <= abs_b;
                    rp    <= '0;
                end
                RUN: if (rq != '0) begin
                    if (rq[0]) rp <= rp + rm;
                    rm <= rm << 1;
                    rq <= rq >> 1;
                end else begin
                    rp    <= neg ? ~rp + 1'b1 : rp;
                    state <= FIN;
                    done  <= 1'b1;
                end
                FIN:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_shift_add_mult.sv
// tb_shift_add_mult: randomized scoreboard bench for shift_add_mult against an arithmetic reference model
module tb_shift_add_mult;
    logic        clk;
    logic        rst_b;
    logic        start;
    logic        mode_signed;
    logic [7:0]  A;
    logic [7:0]  B;
    logic        rdy;
    logic        done;
    logic [15:0] P;

    typedef struct {
        logic [15:0] p;
        int          de;
    } exp_t;

    exp_t        sb[$];
    int          n_chk = 0;
    int          n_fail = 0;
    int          edge_n = 0;
    int          load_edge = -1;
    logic        hold_valid = 1'b0;
    logic [15:0] held_p = '0;

    shift_add_mult #(.WIDTH(8)) dut (
        .clk(clk), .rst_b(rst_b), .start(start), .mode_signed(mode_signed),
        .A(A), .B(B), .rdy(rdy), .done(done), .P(P)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    // product is plain integer multiplication; done edge follows from the bit length of |B|
    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic s, input int e0);
        exp_t r;
        int   pa, pb, prod, absb, k;
        if (s) begin
            pa = int'($signed(a));
            pb = int'($signed(b));
        end else begin
            pa = int'(a);
            pb = int'(b);
        end
        prod = pa * pb;
        r.p  = prod[15:0];
        absb = (pb < 0) ? -pb : pb;
        k    = 0;
        for (int i = 0; i < 16; i++) if (absb[i]) k = i + 1;
        r.de = e0 + k + 1;
        return r;
    endfunction

    // accepted starts are seen at the sampling edge and pushed to the scoreboard
    always @(posedge clk) begin
        edge_n++;
        if (rst_b && start && rdy) begin
            sb.push_back(model(A, B, mode_signed, edge_n));
            load_edge  = edge_n;
            hold_valid = 1'b0;
        end
    end

    // monitor: compares on done, and checks P is cleared after load and held while idle
    always @(negedge clk) begin
        if (rst_b) begin
            if (edge_n == load_edge) check("p_cleared_after_load", int'(P), 0);
            if (hold_valid && rdy) check("p_hold_idle", int'(P), int'(held_p));
            if (done) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL done_spurious: got done=1 with no pending request (edge %0d)", edge_n);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("product", int'(P), int'(e.p));
                    check("done_cycle", edge_n, e.de);
                    check("rdy_low_in_done", int'(rdy), 0);
                    held_p     = e.p;
                    hold_valid = 1'b1;
                end
            end
        end
    end

    task automatic wait_rdy();
        int n = 0;
        while (!rdy && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!rdy) begin
            n_chk++;
            n_fail++;
            $display("FAIL wait_rdy: got rdy=0 after %0d cycles, expected 1", n);
        end
    endtask

    task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic s);
        wait_rdy();
        A           = a;
        B           = b;
        mode_signed = s;
        start       = 1'b1;
        @(negedge clk);
        start       = 1'b0;
        A           = 8'($urandom);
        B           = 8'($urandom);
        mode_signed = 1'($urandom);
    endtask

    initial begin
        int n;
        rst_b       = 1'b0;
        start       = 1'b0;
        mode_signed = 1'b0;
        A           = '0;
        B           = '0;
        repeat (2) @(negedge clk);
        check("reset_rdy", int'(rdy), 1);
        check("reset_done", int'(done), 0);
        check("reset_p", int'(P), 0);
        rst_b = 1'b1;
        @(negedge clk);

        issue(8'd13, 8'd11, 1'b0);
        issue(8'd255, 8'd255, 1'b0);
        issue(8'h80, 8'h80, 1'b1);
        issue(8'hF9, 8'd5, 1'b1);
        issue(8'd6, 8'hFF, 1'b1);
        issue(8'hF9, 8'd5, 1'b0);
        issue(8'd200, 8'd0, 1'b0);
        issue(8'd0, 8'h81, 1'b0);
        issue(8'h7F, 8'h80, 1'b1);
        issue(8'h80, 8'h01, 1'b1);

        for (int i = 0; i < 40; i++) begin
            logic [7:0] rb;
            rb = 8'($urandom);
            if (i % 4 == 0) rb = rb >> $urandom_range(7, 3);
            issue(8'($urandom), rb, 1'($urandom));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        for (int i = 0; i < 60; i++) begin
            start       = 1'b1;
            A           = 8'($urandom);
            B           = 8'($urandom);
            mode_signed = 1'($urandom);
            @(negedge clk);
        end
        start = 1'b0;

        issue(8'd255, 8'd255, 1'b0);
        repeat (3) @(negedge clk);
        rst_b      = 1'b0;
        sb.delete();
        hold_valid = 1'b0;
        load_edge  = -1;
        #2;
        check("midrun_reset_rdy", int'(rdy), 1);
        check("midrun_reset_done", int'(done), 0);
        check("midrun_reset_p", int'(P), 0);
        #2;
        rst_b = 1'b1;
        @(negedge clk);
        issue(8'd3, 8'd4, 1'b0);

        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain: got %0d pending results, expected 0", sb.size());
        end
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
